rx_edge_sampler: RTL and testbench

- Upstream neighbour of the UART RX stop/parity/deserializer checkers.
- Counts oversampling edges and bit periods while the RX FSM enables counting.
- Takes three samples of RX_IN around the bit centre and produces a majority-voted sampled_bit with a one-cycle sample_valid strobe.
- Its edge_cnt and bit_cnt outputs drive the RX FSM's frame sequencing.

---
 rtl/uart_rx_pkg.sv | 13 +
 rtl/edge_bit_counter.sv | 65 ++++++
 rtl/rx_edge_sampler.sv | 99 +++++++++
 tb/tb_rx_edge_sampler.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared defaults and helpers for the UART RX edge sampler
package uart_rx_pkg;

    localparam int DEF_PRESCALE_W = 6;
    localparam int DEF_BIT_CNT_W  = 4;
    localparam int MIN_PRESCALE   = 8;

    // Two-of-three vote; a single-cycle glitch on one sample cannot flip the bit.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/edge_bit_counter.sv
// rtl/edge_bit_counter.sv - prescale latch plus edge and bit-period counters
module edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = DEF_PRESCALE_W,
    parameter int BIT_CNT_W  = DEF_BIT_CNT_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cnt_en_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic [PRESCALE_W-1:0] edge_cnt_o,
    output logic [BIT_CNT_W-1:0]  bit_cnt_o,
    output logic [PRESCALE_W-1:0] mid_o
);

    localparam logic [PRESCALE_W-1:0] MIN_P = PRESCALE_W'(MIN_PRESCALE);

    logic                  en_prev_q;
    logic [PRESCALE_W-1:0] p_q, p_d;
    logic [PRESCALE_W-1:0] edge_q, edge_d;
    logic [BIT_CNT_W-1:0]  bit_q, bit_d;

    // Next-state: latch P on the rising enable, count edges, wrap into bit periods.
    always_comb begin
        p_d    = p_q;
        edge_d = edge_q;
        bit_d  = bit_q;
        if (!cnt_en_i) begin
            edge_d = '0;
            bit_d  = '0;
        end else begin
            // The first enabled edge compares against the freshly latched P.
            if (!en_prev_q) begin
                p_d = (prescale_i < MIN_P) ? MIN_P : prescale_i;
            end
            if (edge_q == p_d - PRESCALE_W'(1)) begin
                edge_d = '0;
                bit_d  = bit_q + BIT_CNT_W'(1);
            end else begin
                edge_d = edge_q + PRESCALE_W'(1);
            end
        end
    end

    // State registers with synchronous reset; P defaults to the minimum ratio.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_prev_q <= 1'b0;
            p_q       <= MIN_P;
            edge_q    <= '0;
            bit_q     <= '0;
        end else begin
            en_prev_q <= cnt_en_i;
            p_q       <= p_d;
            edge_q    <= edge_d;
            bit_q     <= bit_d;
        end
    end

    assign edge_cnt_o = edge_q;
    assign bit_cnt_o  = bit_q;
    assign mid_o      = p_q >> 1;

endmodule

// File: rtl/rx_edge_sampler.sv
// rtl/rx_edge_sampler.sv - 3-sample majority voter for UART RX; RX_SYNC_EN adds a 2-flop RX_IN synchronizer
module rx_edge_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = DEF_PRESCALE_W,
    parameter int BIT_CNT_W  = DEF_BIT_CNT_W
) (
    input  logic                  clk_RX,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  cnt_en,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  sampled_bit,
    output logic                  sample_valid
);

    logic [PRESCALE_W-1:0] mid;
    logic                  rx_s;

    edge_bit_counter #(
        .PRESCALE_W (PRESCALE_W),
        .BIT_CNT_W  (BIT_CNT_W)
    ) u_counter (
        .clk_i      (clk_RX),
        .rst_i      (rst),
        .cnt_en_i   (cnt_en),
        .prescale_i (Prescale),
        .edge_cnt_o (edge_cnt),
        .bit_cnt_o  (bit_cnt),
        .mid_o      (mid)
    );

`ifdef RX_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchronizer, reset to the idle-high line level.
    always_ff @(posedge clk_RX) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], RX_IN};
        end
    end

    assign rx_s = sync_q[1];
`else
    assign rx_s = RX_IN;
`endif

    logic s0_q, s0_d;
    logic s1_q, s1_d;
    logic sbit_q, sbit_d;
    logic valid_q, valid_d;

    // Capture samples at mid-1 and mid, vote with the live sample at mid+1.
    always_comb begin
        s0_d    = s0_q;
        s1_d    = s1_q;
        sbit_d  = sbit_q;
        valid_d = 1'b0;
        if (!cnt_en) begin
            // Dropping enable discards partial samples; the last voted bit stays.
            s0_d = 1'b0;
            s1_d = 1'b0;
        end else begin
            if (edge_cnt == mid - PRESCALE_W'(1)) begin
                s0_d = rx_s;
            end
            if (edge_cnt == mid) begin
                s1_d = rx_s;
            end
            if (edge_cnt == mid + PRESCALE_W'(1)) begin
                sbit_d  = maj3(s0_q, s1_q, rx_s);
                valid_d = 1'b1;
            end
        end
    end

    // Sample and result registers with synchronous reset.
    always_ff @(posedge clk_RX) begin
        if (rst) begin
            s0_q    <= 1'b0;
            s1_q    <= 1'b0;
            sbit_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            sbit_q  <= sbit_d;
            valid_q <= valid_d;
        end
    end

    assign sampled_bit  = sbit_q;
    assign sample_valid = valid_q;

endmodule

// File: tb/tb_rx_edge_sampler.sv
// tb/tb_rx_edge_sampler.sv - scoreboard bench for rx_edge_sampler against a frame-level model
module tb_rx_edge_sampler;

    logic       clk_RX = 1'b0;
    logic       rst = 1'b1;
    logic       RX_IN = 1'b1;
    logic [5:0] Prescale = 6'd8;
    logic       cnt_en = 1'b0;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       sampled_bit;
    logic       sample_valid;

    rx_edge_sampler dut (
        .clk_RX       (clk_RX),
        .rst          (rst),
        .RX_IN        (RX_IN),
        .Prescale     (Prescale),
        .cnt_en       (cnt_en),
        .edge_cnt     (edge_cnt),
        .bit_cnt      (bit_cnt),
        .sampled_bit  (sampled_bit),
        .sample_valid (sample_valid)
    );

    always #5 clk_RX = ~clk_RX;

    typedef struct {
        int b;
        int e;
        int bc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   checking = 0;

    // Frame-level model: n = enabled edges since enable rose, hist = line value at each.
    int   m_n = 0;
    int   m_p = 8;
    bit   m_active = 0;
    int   m_sbit = 0;
    int   m_valid = 0;
    int   m_edge = 0;
    int   m_bit = 0;
    int   hist[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, input bit en, input int pre, input bit rx);
        int pos;
        int mid;
        int votes;
        m_valid = 0;
        if (r) begin
            m_active = 0;
            m_n      = 0;
            m_p      = 8;
            m_sbit   = 0;
            hist.delete();
        end else if (!en) begin
            m_active = 0;
            m_n      = 0;
            hist.delete();
        end else begin
            if (!m_active) begin
                m_active = 1;
                m_p      = (pre < 8) ? 8 : pre;
                m_n      = 0;
            end
            pos = m_n % m_p;
            mid = m_p / 2;
            hist.push_back(int'(rx));
            if (pos == mid + 1) begin
                votes   = hist[m_n-2] + hist[m_n-1] + hist[m_n];
                m_sbit  = (votes >= 2) ? 1 : 0;
                m_valid = 1;
                sb_q.push_back('{m_sbit, (m_n + 1) % m_p, ((m_n + 1) / m_p) % 16});
            end
            m_n++;
        end
        m_edge = m_n % m_p;
        m_bit  = (m_n / m_p) % 16;
    endtask

    task automatic step(input bit r, input bit en, input int pre, input bit rx);
        @(negedge clk_RX);
        #1;
        rst      = r;
        cnt_en   = en;
        Prescale = 6'(pre);
        RX_IN    = rx;
        @(posedge clk_RX);
        model_update(r, en, pre, rx);
    endtask

    // Monitor: compare visible counters every cycle, pop the scoreboard on each strobe.
    always @(negedge clk_RX) begin
        if (checking) begin
            check("edge_cnt", int'(edge_cnt), m_edge);
            check("bit_cnt", int'(bit_cnt), m_bit);
            check("sampled_bit", int'(sampled_bit), m_sbit);
            check("sample_valid", int'(sample_valid), m_valid);
            if (sample_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_strobe", 1, 0);
                end else begin
                    exp_t x;
                    x = sb_q.pop_front();
                    check("strobe_bit", int'(sampled_bit), x.b);
                    check("strobe_edge", int'(edge_cnt), x.e);
                    check("strobe_bitcnt", int'(bit_cnt), x.bc);
                end
            end
        end
    end

    initial begin
        int pats[3];
        int plist[8];
        int p;
        int len;
        int chg;
        pats  = '{0, 1, 1};
        plist = '{8, 16, 32, 4, 0, 12, 9, 20};

        step(1, 0, 8, 1);
        checking = 1;
        step(1, 0, 8, 1);
        step(0, 0, 8, 1);

        // Clean 1 at P=8, then disable
        for (int k = 0; k < 8; k++) step(0, 1, 8, 1);
        step(0, 0, 8, 1);

        // Glitch at edge_cnt=4 only
        for (int k = 0; k < 8; k++) step(0, 1, 8, k == 4);
        step(0, 0, 8, 0);

        // Samples 1,0,1 at edge_cnt 3,4,5
        for (int k = 0; k < 8; k++) step(0, 1, 8, (k == 3) || (k == 5));
        step(0, 0, 8, 0);

        // Three bits 0,1,1 at P=16
        for (int k = 0; k < 48; k++) step(0, 1, 16, pats[k/16][0]);
        step(0, 0, 16, 1);

        // Prescale changed 16 -> 8 mid-frame
        for (int k = 0; k < 40; k++) step(0, 1, (k < 5) ? 16 : 8, $urandom_range(1));
        step(0, 0, 4, 1);

        // Re-enable with Prescale=4
        for (int k = 0; k < 17; k++) step(0, 1, 4, $urandom_range(1));
        step(0, 0, 8, 1);

        // Drop enable at edge_cnt=4, after s0 was captured
        for (int k = 0; k < 4; k++) step(0, 1, 8, 1);
        step(0, 0, 8, 1);
        step(0, 0, 8, 1);

        // Reset mid-frame
        for (int k = 0; k < 10; k++) step(0, 1, 8, 1);
        step(1, 1, 8, 1);
        step(0, 0, 8, 1);

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            p   = plist[$urandom_range(7)];
            len = $urandom_range(80, 1);
            chg = $urandom_range(9);
            for (int k = 0; k < len; k++) begin
                step(($urandom_range(199) == 0), 1,
                     (chg == 0 && k > len / 2) ? int'($urandom_range(40)) : p,
                     $urandom_range(1));
            end
            for (int g = 0; g <= int'($urandom_range(3)); g++) step(0, 0, p, 1);
        end

        @(negedge clk_RX);
        #1;
        check("scoreboard_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
